mem_port_arbiter: RTL and testbench

Shares the CPU's single-port unified memory between the instruction-fetch requester and the data (load/store) requester of the datapath under top_level. It sequences each access as a fixed-latency memory transaction and returns read data with a one-cycle acknowledge pulse. Data requests have priority, and a starvation guard guarantees fetch progress. It sits between the fetch/memory stages and the memory instance.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/mem_lat_counter.sv | 29 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem: default bus widths,
// arbiter FSM state encoding and transaction owner encoding.
package cpu_mem_pkg;

   // Default widths shared with the datapath.
   localparam int CPU_ADDR_W = 16;
   localparam int CPU_DATA_W = 16;

   // Arbiter FSM states.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Owner of the transaction currently in flight.
   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag. It counts down to zero and
// stays there. Used to time the fixed memory read latency.
module mem_lat_counter #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   // Load takes precedence; decrement stops at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// data load/store. Each access is one mem_en strobe followed by a fixed
// latency wait, then a one-cycle ack to the owner. Data wins ties unless
// fetch has lost MAX_WAIT arbitrations in a row.
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W   = CPU_ADDR_W,
   parameter int DATA_W   = CPU_DATA_W,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int STV_W = $clog2(MAX_WAIT + 1);

   logic [1:0]       state_reg;
   logic             owner_reg;
   logic [STV_W-1:0] starve_cnt_reg;

   logic lat_load;
   logic lat_dec;
   logic lat_zero;
   logic fetch_starved;
   logic grant_d;
   logic grant_if;

   // Fetch overrides data priority once it has been starved long enough.
   assign fetch_starved = (starve_cnt_reg >= STV_W'(MAX_WAIT));
   assign grant_d       = d_req && !(if_req && fetch_starved);
   assign grant_if      = if_req && !grant_d;

   // Counter is armed at the grant edge and runs down through WAIT.
   assign lat_load = (state_reg == ST_IDLE) && (if_req || d_req);
   assign lat_dec  = (state_reg == ST_WAIT);

   mem_lat_counter #(
      .WIDTH (LAT_W)
   ) u_lat_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (lat_load),
      .load_val (LAT_W'(MEM_LAT)),
      .dec      (lat_dec),
      .zero     (lat_zero)
   );

   // Transaction FSM with all outputs registered; acks and mem_en default low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= OWN_IF;
         starve_cnt_reg <= '0;
         if_ack         <= 1'b0;
         if_rdata       <= '0;
         d_ack          <= 1'b0;
         d_rdata        <= '0;
         mem_en         <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
      end else begin
         mem_en <= 1'b0;
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (grant_d) begin
                  owner_reg <= OWN_D;
                  mem_addr  <= d_addr;
                  mem_we    <= d_we;
                  mem_wdata <= d_wdata;
                  mem_en    <= 1'b1;
                  state_reg <= ST_WAIT;
                  // Fetch lost this round; count it, saturating.
                  if (if_req && !fetch_starved) begin
                     starve_cnt_reg <= starve_cnt_reg + 1'b1;
                  end
               end else if (grant_if) begin
                  owner_reg      <= OWN_IF;
                  mem_addr       <= if_addr;
                  mem_we         <= 1'b0;
                  mem_en         <= 1'b1;
                  state_reg      <= ST_WAIT;
                  starve_cnt_reg <= '0;
               end
            end
            ST_WAIT: begin
               if (lat_zero) begin
                  if (owner_reg == OWN_D) begin
                     if (!mem_we) begin
                        d_rdata <= mem_rdata;
                     end
                     d_ack <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// accesses and acks into queues; a monitor pops and compares them as the
// DUT presents mem_en, if_ack and d_ack.
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
   } mem_exp_t;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_ack;
   logic [15:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_en_cyc = 0;
   bit spacing_on = 0;
   bit sp_have = 0;

   mem_exp_t    mem_q[$];
   logic [15:0] if_q[$];
   logic [15:0] d_q[$];

   logic        p1_v;
   logic [15:0] p1_a;

   mem_port_arbiter #(
      .ADDR_W   (16),
      .DATA_W   (16),
      .MEM_LAT  (2),
      .MAX_WAIT (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed memory contents seen by reads.
   function automatic logic [15:0] mem_f(input logic [15:0] a);
      case (a)
         16'h0010: return 16'hABCD;
         16'h0020: return 16'h1111;
         16'h0300: return 16'h3333;
         16'h0400: return 16'h4444;
         16'h0500: return 16'h5555;
         16'h0FFF: return 16'hF0F0;
         default:  return 16'hDEAD;
      endcase
   endfunction

   // Memory model, MEM_LAT=2: sampled at the strobe edge, data valid only
   // for the one cycle after the following edge.
   always @(posedge clk) begin
      p1_v      <= mem_en && !mem_we;
      p1_a      <= mem_addr;
      mem_rdata <= p1_v ? mem_f(p1_a) : 16'hDEAD;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: sample registered outputs just after each rising edge.
   always @(posedge clk) begin
      mem_exp_t    em;
      logic [15:0] ed;
      #1;
      cyc++;
      if (rst) begin
         if (mem_en) begin
            if (mem_q.size() == 0) begin
               check("mem_en_unexpected", 1, 0);
            end else begin
               em = mem_q.pop_front();
               check("mem_addr", mem_addr, em.addr);
               check("mem_we", mem_we, em.we);
               if (em.we) check("mem_wdata", mem_wdata, em.wdata);
            end
            if (spacing_on && sp_have) check("grant_spacing", cyc - last_en_cyc, 5);
            sp_have     = spacing_on;
            last_en_cyc = cyc;
         end
         if (if_ack) begin
            if (if_q.size() == 0) begin
               check("if_ack_unexpected", 1, 0);
            end else begin
               ed = if_q.pop_front();
               check("if_rdata", if_rdata, ed);
               check("if_ack_latency", cyc - last_en_cyc, 3);
            end
         end
         if (d_ack) begin
            if (d_q.size() == 0) begin
               check("d_ack_unexpected", 1, 0);
            end else begin
               ed = d_q.pop_front();
               check("d_rdata", d_rdata, ed);
               check("d_ack_latency", cyc - last_en_cyc, 3);
            end
         end
      end
   end

   task automatic wait_if_ack();
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (if_ack) seen = 1;
      end
      if (!seen) check("if_ack_timeout", 0, 1);
      if_req = 1'b0;
   endtask

   task automatic wait_d_ack();
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (d_ack) seen = 1;
      end
      if (!seen) check("d_ack_timeout", 0, 1);
      d_req = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_if_ack"}, if_ack, 0);
      check({tag, "_if_rdata"}, if_rdata, 0);
      check({tag, "_d_ack"}, d_ack, 0);
      check({tag, "_d_rdata"}, d_rdata, 0);
      check({tag, "_mem_en"}, mem_en, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask

   initial begin
      int n;
      bit seen;
      rst     = 1'b0;
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // 1: single fetch
      mem_q.push_back('{addr: 16'h0010, we: 1'b0, wdata: 16'h0000});
      if_q.push_back(16'hABCD);
      if_addr = 16'h0010;
      if_req  = 1'b1;
      wait_if_ack();
      repeat (3) @(negedge clk);
      check("if_rdata_hold", if_rdata, 16'hABCD);
      $display("txn1 fetch 0x0010 done");

      // 2: data write, d_rdata keeps its previous value
      mem_q.push_back('{addr: 16'h0200, we: 1'b1, wdata: 16'h1234});
      d_q.push_back(16'h0000);
      d_we    = 1'b1;
      d_addr  = 16'h0200;
      d_wdata = 16'h1234;
      d_req   = 1'b1;
      wait_d_ack();
      @(negedge clk);
      check("if_rdata_hold2", if_rdata, 16'hABCD);
      $display("txn2 write 0x0200 done");

      // 3: both requesting continuously: D D D IF D D D IF
      for (int k = 0; k < 8; k++) begin
         if (k == 3 || k == 7) begin
            mem_q.push_back('{addr: 16'h0020, we: 1'b0, wdata: 16'h0000});
            if_q.push_back(16'h1111);
         end else begin
            mem_q.push_back('{addr: 16'h0300, we: 1'b0, wdata: 16'hBEEF});
            d_q.push_back(16'h3333);
         end
      end
      spacing_on = 1;
      d_we    = 1'b0;
      d_addr  = 16'h0300;
      d_wdata = 16'hBEEF;
      if_addr = 16'h0020;
      d_req   = 1'b1;
      if_req  = 1'b1;
      n = 0;
      for (int i = 0; i < 100 && n < 8; i++) begin
         @(negedge clk);
         if (if_ack || d_ack) n++;
      end
      check("arb_ack_count", n, 8);
      d_req      = 1'b0;
      if_req     = 1'b0;
      spacing_on = 0;
      @(negedge clk);
      $display("txn3 arbitration sequence done, acks=%0d", n);

      // 4: fetch address changes after grant
      mem_q.push_back('{addr: 16'h0020, we: 1'b0, wdata: 16'h0000});
      if_q.push_back(16'h1111);
      if_addr = 16'h0020;
      if_req  = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_en) seen = 1;
      end
      check("t4_grant_seen", seen, 1);
      if_addr = 16'h0FFF;
      @(negedge clk);
      check("t4_mem_addr_held", mem_addr, 16'h0020);
      wait_if_ack();
      check("t4_mem_addr_after", mem_addr, 16'h0020);
      $display("txn4 fetch with addr change done");

      // 5: reset in the middle of a data read
      mem_q.push_back('{addr: 16'h0400, we: 1'b0, wdata: 16'hBEEF});
      d_we   = 1'b0;
      d_addr = 16'h0400;
      d_req  = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (mem_en) seen = 1;
      end
      check("t5_grant_seen", seen, 1);
      rst = 1'b0;
      #1;
      check_outputs_zero("midreset");
      @(negedge clk);
      mem_q.push_back('{addr: 16'h0400, we: 1'b0, wdata: 16'hBEEF});
      d_q.push_back(16'h4444);
      rst = 1'b1;
      wait_d_ack();
      $display("txn5 reset mid-read then re-issue done");

      // 6: single data read pulse, then quiet
      mem_q.push_back('{addr: 16'h0500, we: 1'b0, wdata: 16'hBEEF});
      d_q.push_back(16'h5555);
      d_addr = 16'h0500;
      d_req  = 1'b1;
      wait_d_ack();
      repeat (15) @(negedge clk);
      check("t6_state_idle", dut.state_reg, ST_IDLE);
      check("t6_d_rdata_hold", d_rdata, 16'h5555);
      $display("txn6 single read 0x0500 done");

      check("mem_q_empty", mem_q.size(), 0);
      check("if_q_empty", if_q.size(), 0);
      check("d_q_empty", d_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
